// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and
// default widths/timeout used by instr_fetch and fetch_timer.
package fetch_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_timer.sv
// Saturating memory-wait counter with a sticky timeout flag that only
// reset can clear.
module fetch_timer
    import fetch_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic inc_i,
    output logic err_o
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != TMAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        err_d = err_q | (cnt_d == TMAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads memory at the PC, holds the word for
// decode, and steers the PC via increment or branch-load strobes.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] execadd,
    output logic              loadPC,
    output logic              incPC,
    output logic [ADDR_W-1:0] address,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ack,
    input  logic              br_take,
    input  logic [ADDR_W-1:0] br_target,
    output logic [15:0]       fetch_count,
    output logic              fetch_err
);

    fetch_state_e      state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              irv_q, irv_d;
    logic              load_q, load_d;
    logic              inc_q, inc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        irv_d   = irv_q;
        load_d  = 1'b0;
        inc_d   = 1'b0;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        // A redirect outranks memory data and decode acknowledge
        if (br_take && (state_q != IDLE)) begin
            load_d  = 1'b1;
            addr_d  = br_target;
            irv_d   = 1'b0;
            state_d = FLUSH;
        end else begin
            unique case (state_q)
                IDLE:  state_d = FETCH;
                FETCH: begin
                    if (mem_ready) begin
                        ir_d    = mem_data;
                        irv_d   = 1'b1;
                        inc_d   = 1'b1;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    if (ir_ack) begin
                        irv_d   = 1'b0;
                        state_d = FETCH;
                    end
                end
                FLUSH: state_d = FETCH;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q    <= '0;
            irv_q   <= 1'b0;
            load_q  <= 1'b0;
            inc_q   <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            irv_q   <= irv_d;
            load_q  <= load_d;
            inc_q   <= inc_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    fetch_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i ((state_d == FETCH) && (state_q != FETCH)),
        .inc_i ((state_q == FETCH) && !mem_ready),
        .err_o (fetch_err)
    );

    assign mem_rd      = (state_q == FETCH);
    assign mem_addr    = mem_rd ? execadd : '0;
    assign loadPC      = load_q;
    assign incPC       = inc_q;
    assign address     = addr_q;
    assign ir          = ir_q;
    assign ir_valid    = irv_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural PC driving execadd.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] execadd;
    logic        loadPC, incPC, mem_rd;
    logic [11:0] address, mem_addr;
    logic        mem_ready;
    logic [15:0] mem_data, ir;
    logic        ir_valid, ir_ack, br_take;
    logic [11:0] br_target;
    logic [15:0] fetch_count;
    logic        fetch_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .execadd     (execadd),
        .loadPC      (loadPC),
        .incPC       (incPC),
        .address     (address),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_data    (mem_data),
        .ir          (ir),
        .ir_valid    (ir_valid),
        .ir_ack      (ir_ack),
        .br_take     (br_take),
        .br_target   (br_target),
        .fetch_count (fetch_count),
        .fetch_err   (fetch_err)
    );

    // PC stage model
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         execadd <= '0;
        else if (loadPC) execadd <= address;
        else if (incPC)  execadd <= execadd + 12'd1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    initial begin
        rst = 1'b1;
        mem_ready = 1'b0;
        mem_data = '0;
        ir_ack = 1'b0;
        br_take = 1'b0;
        br_target = '0;

        @(negedge clk);
        check("rst_ir", 32'(ir), 32'h0);
        check("rst_irv", 32'(ir_valid), 32'h0);
        check("rst_load", 32'(loadPC), 32'h0);
        check("rst_inc", 32'(incPC), 32'h0);
        check("rst_addr", 32'(address), 32'h0);
        check("rst_rd", 32'(mem_rd), 32'h0);
        check("rst_cnt", 32'(fetch_count), 32'h0);
        check("rst_err", 32'(fetch_err), 32'h0);
        rst = 1'b0;

        // first fetch
        @(negedge clk);
        check("f1_rd", 32'(mem_rd), 32'h1);
        check("f1_maddr", 32'(mem_addr), 32'h000);
        mem_ready = 1'b1;
        mem_data = 16'h1A2B;
        @(negedge clk);
        mem_ready = 1'b0;
        check("f1_ir", 32'(ir), 32'h1A2B);
        check("f1_irv", 32'(ir_valid), 32'h1);
        check("f1_inc", 32'(incPC), 32'h1);
        check("f1_load", 32'(loadPC), 32'h0);
        check("f1_cnt", 32'(fetch_count), 32'h1);

        // hold without acknowledge
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_ir", 32'(ir), 32'h1A2B);
            check("hold_rd", 32'(mem_rd), 32'h0);
            check("hold_inc", 32'(incPC), 32'h0);
        end
        ir_ack = 1'b1;
        @(negedge clk);
        ir_ack = 1'b0;
        check("ack_rd", 32'(mem_rd), 32'h1);
        check("ack_maddr", 32'(mem_addr), 32'h001);
        check("ack_irv", 32'(ir_valid), 32'h0);

        // branch coincident with memory ready
        mem_ready = 1'b1;
        mem_data = 16'hDEAD;
        br_take = 1'b1;
        br_target = 12'h3F0;
        @(negedge clk);
        mem_ready = 1'b0;
        br_take = 1'b0;
        check("br_load", 32'(loadPC), 32'h1);
        check("br_addr", 32'(address), 32'h3F0);
        check("br_inc", 32'(incPC), 32'h0);
        check("br_irv", 32'(ir_valid), 32'h0);
        check("br_cnt", 32'(fetch_count), 32'h1);
        check("br_rd", 32'(mem_rd), 32'h0);
        @(negedge clk);
        check("br_res_rd", 32'(mem_rd), 32'h1);
        check("br_res_maddr", 32'(mem_addr), 32'h3F0);
        check("br_res_load", 32'(loadPC), 32'h0);

        // memory timeout
        repeat (14) @(negedge clk);
        check("to14_err", 32'(fetch_err), 32'h0);
        check("to14_rd", 32'(mem_rd), 32'h1);
        @(negedge clk);
        check("to15_err", 32'(fetch_err), 32'h1);
        mem_ready = 1'b1;
        mem_data = 16'hBEEF;
        @(negedge clk);
        mem_ready = 1'b0;
        check("to_ir", 32'(ir), 32'hBEEF);
        check("to_cnt", 32'(fetch_count), 32'h2);
        check("to_err_hold", 32'(fetch_err), 32'h1);
        ir_ack = 1'b1;
        @(negedge clk);
        ir_ack = 1'b0;
        check("to_maddr", 32'(mem_addr), 32'h3F1);
        check("to_err_sticky", 32'(fetch_err), 32'h1);

        // redirect re-issued while flushing
        br_take = 1'b1;
        br_target = 12'h100;
        @(negedge clk);
        check("fl1_addr", 32'(address), 32'h100);
        br_target = 12'h155;
        @(negedge clk);
        br_take = 1'b0;
        check("fl2_load", 32'(loadPC), 32'h1);
        check("fl2_addr", 32'(address), 32'h155);
        check("fl2_rd", 32'(mem_rd), 32'h0);
        @(negedge clk);
        check("fl_res_rd", 32'(mem_rd), 32'h1);
        check("fl_res_maddr", 32'(mem_addr), 32'h155);

        // counter wrap from 0xFFFF
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        check("wrap_pre", 32'(fetch_count), 32'hFFFF);
        mem_ready = 1'b1;
        mem_data = 16'h5A5A;
        @(negedge clk);
        mem_ready = 1'b0;
        check("wrap_cnt", 32'(fetch_count), 32'h0000);
        check("wrap_ir", 32'(ir), 32'h5A5A);

        // asynchronous reset in the middle of a fetch
        ir_ack = 1'b1;
        @(negedge clk);
        ir_ack = 1'b0;
        check("pre_rst_rd", 32'(mem_rd), 32'h1);
        #2;
        rst = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("arst_rd", 32'(mem_rd), 32'h0);
        check("arst_ir", 32'(ir), 32'h0);
        check("arst_err", 32'(fetch_err), 32'h0);
        check("arst_addr", 32'(address), 32'h0);
        @(negedge clk);
        check("arst_cnt", 32'(fetch_count), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rs_rd", 32'(mem_rd), 32'h1);
        check("rs_maddr", 32'(mem_addr), 32'h000);
        check("rs_cnt", 32'(fetch_count), 32'h0);
        mem_data = 16'h0F0F;
        @(negedge clk);
        mem_ready = 1'b0;
        check("rs_ir", 32'(ir), 32'h0F0F);
        check("rs_cnt1", 32'(fetch_count), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
